layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Controller that runs the feed-forward neuron array one layer at a time. It latches the network input vector and issues a one-cycle `start` to the active layer. It collects every neuron's `end_` pulse and captures the layer outputs as the next layer's inputs. After the last layer it presents the network result. It sits between the host interface and the neuron array and replaces the direct end-to-start chaining between layers with an explicit, timeout-guarded schedule.

## Interface
- `NUM_LAYERS`, default 3: number of layers sequenced (≥1).
- `NEURONS`, default 9: neurons per hidden layer; width of end/output buses.
- `LAST_N`, default 1: neurons active in the final layer (1..NEURONS).
- `DATA_W`, default 9: width of one neuron output / one input element.
- `TIMEOUT`, default 255: max WAIT cycles per layer before error (≥1).

Ports:
- `clk`, in, 1: the single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a network evaluation; sampled only in IDLE/ERR.
- `net_in`, in, NEURONS*DATA_W: network input vector, latched on accepted start.
- `layer_start`, out, 1: one-cycle start pulse to the layer selected by `layer_idx`.
- `layer_idx`, out, clog2(NUM_LAYERS) (min 1): index of the layer currently running.
- `layer_in`, out, NEURONS*DATA_W: registered input vector broadcast to the active layer.
- `neuron_end`, in, NEURONS: per-neuron `end_` pulses from the active layer.
- `neuron_out`, in, NEURONS*DATA_W: per-neuron outputs of the active layer; element i is bits [i*DATA_W +: DATA_W].
- `busy`, out, 1: high from accepted start until DONE or ERR is entered.
- `done`, out, 1: one-cycle pulse, result valid.
- `result`, out, DATA_W: element 0 of the last layer's output, held until the next accepted start.
- `error`, out, 1: watchdog expired; sticky until next accepted start.

## Operation
- States: IDLE, FIRE, WAIT, CAPTURE, DONE, ERR.
- IDLE/ERR + `start`:
  - latch `net_in` into `layer_in`;
  - `layer_idx`=0;
  - clear `error` and `result`;
  - go to FIRE.
- FIRE:
  - `layer_start`=1 for exactly this cycle;
  - clear the pending mask and the watchdog;
  - go to WAIT.
- WAIT:
  - OR `neuron_end` into the sticky pending mask each cycle.
  - Active mask is all NEURONS bits, or the low LAST_N bits when `layer_idx`==NUM_LAYERS-1. Inactive bits are ignored.
  - When (pending | neuron_end) covers the active mask, go to CAPTURE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT with the mask incomplete, go to ERR.
- CAPTURE:
  - Not last layer: `layer_in` ← `neuron_out`, increment `layer_idx`, go to FIRE.
  - Last layer: `result` ← `neuron_out` element 0, go to DONE.
- DONE: `done`=1 for one cycle, go to IDLE.
- ERR:
  - `error`=1, `busy`=0;
  - `layer_idx` and `layer_in` hold their values for debug;
  - leave only via `start`.
- `start` in FIRE/WAIT/CAPTURE/DONE is ignored (no queueing).
- `neuron_end` outside WAIT is ignored. Repeated pulses from the same neuron count once.
- `busy`=1 in FIRE, WAIT, CAPTURE; 0 in IDLE, DONE, ERR.

## Timing
- Reset values: state IDLE; `layer_start`, `busy`, `done`, `error` = 0; `layer_idx`, `layer_in`, `result`, pending mask, watchdog = 0.
- All outputs are registered (Moore on state).
- Per layer: FIRE 1 cycle + WAIT n≥1 cycles + CAPTURE 1 cycle.
- Minimum latency, NUM_LAYERS=3, with all ends arriving in the first WAIT cycle:
  - start sampled at cycle 0;
  - FIRE at cycles 1, 4, 7;
  - CAPTURE at 3, 6, 9;
  - `done` high at cycle 10;
  - IDLE at 11, where a new start is accepted.
- End pulses split across WAIT cycles extend WAIT to the cycle in which the last active bit arrives. CAPTURE follows on the next cycle.
- Watchdog: ERR is entered on the edge after the TIMEOUT-th incomplete WAIT cycle.
- `rst_n` low at any time: immediate asynchronous return to reset values. An in-flight evaluation is abandoned with no `done`.

## Test plan
- Reset mid-WAIT of layer 1 → all outputs 0 during reset. After release: IDLE, `busy`=0, no `done`.
- Nominal run: `net_in` element i = i. Neurons ack 1 cycle after `layer_start` with outputs 0x10+layer. → `layer_start` at cycles 1/4/7, `done` at 10, `result`=0x012, `layer_in` = 0x011 on all elements during layer 2.
- Staggered ends: layer 0 neuron i ends i cycles into WAIT, with neuron 3 pulsing twice. → CAPTURE the cycle after neuron 8's pulse; duplicate pulse harmless.
- Last layer with LAST_N=1: only neuron 0 ends, the others stay silent. → completes without error.
- Timeout with TIMEOUT=4: neuron 5 never ends in layer 1. → ERR after 4 WAIT cycles, `error`=1, `layer_idx`=1, no `done`. Then `start` → `error` clears and the run restarts at layer 0.
- `start` held high throughout a run → exactly one evaluation per IDLE visit; a second run starts at cycle 11.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer-by-layer scheduler for the feed-forward neuron array.
// Fires each layer, gathers end pulses, forwards outputs, guards with a watchdog.
module layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int NEURONS = 9,
  parameter int LAST_N = 1,
  parameter int DATA_W = 9,
  parameter int TIMEOUT = 255,
  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int VW = NEURONS * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [VW-1:0]     net_in,
  output logic              layer_start,
  output logic [IW-1:0]     layer_idx,
  output logic [VW-1:0]     layer_in,
  input  logic [NEURONS-1:0] neuron_end,
  input  logic [VW-1:0]     neuron_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [NEURONS-1:0] ALL_M = '1;
  localparam logic [NEURONS-1:0] LAST_M = ALL_M >> (NEURONS - LAST_N);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_WAIT, S_CAP, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;
  logic [NEURONS-1:0] pend, pend_nx, seen, act_m;
  logic [WW-1:0] wd, wd_nx;
  logic [IW-1:0] idx_nx;
  logic [VW-1:0] in_nx;
  logic [DATA_W-1:0] res_nx;
  logic last;

  assign last = (layer_idx == IW'(NUM_LAYERS - 1));
  assign act_m = last ? LAST_M : ALL_M;
  assign seen = pend | neuron_end;

  always_comb begin
    state_nx = state;
    pend_nx = pend;
    wd_nx = wd;
    idx_nx = layer_idx;
    in_nx = layer_in;
    res_nx = result;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          in_nx = net_in;
          idx_nx = '0;
          res_nx = '0;
          state_nx = S_FIRE;
        end
      end
      S_FIRE: begin
        pend_nx = '0;
        wd_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        pend_nx = seen;
        if ((seen & act_m) == act_m) begin
          state_nx = S_CAP;
        end else begin
          wd_nx = wd + WW'(1);
          if (wd == WW'(TIMEOUT - 1)) state_nx = S_ERR;
        end
      end
      S_CAP: begin
        if (last) begin
          res_nx = neuron_out[DATA_W-1:0];
          state_nx = S_DONE;
        end else begin
          in_nx = neuron_out;
          idx_nx = layer_idx + IW'(1);
          state_nx = S_FIRE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they toggle with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pend <= '0;
      wd <= '0;
      layer_idx <= '0;
      layer_in <= '0;
      result <= '0;
      layer_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      pend <= pend_nx;
      wd <= wd_nx;
      layer_idx <= idx_nx;
      layer_in <= in_nx;
      result <= res_nx;
      layer_start <= (state_nx == S_FIRE);
      busy <= (state_nx == S_FIRE) || (state_nx == S_WAIT)
           || (state_nx == S_CAP);
      done <= (state_nx == S_DONE);
      error <= (state_nx == S_ERR);
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed table, corner sequences and random runs
// against a timeline model derived from per-neuron end delays.
module tb_layer_sequencer;

  localparam int NL = 3;
  localparam int N = 9;
  localparam int DW = 9;
  localparam int VW = N * DW;
  localparam int LN = 1;
  localparam int TOA = 255;
  localparam int TOB = 4;
  localparam int NEVER = 1000;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [VW-1:0] net_in = '0;
  logic [N-1:0] neuron_end = '0;
  logic [VW-1:0] neuron_out = '0;

  logic a_ls, a_busy, a_done, a_err;
  logic [1:0] a_idx;
  logic [VW-1:0] a_lin;
  logic [DW-1:0] a_res;
  logic b_ls, b_busy, b_done, b_err;
  logic [1:0] b_idx;
  logic [VW-1:0] b_lin;
  logic [DW-1:0] b_res;

  logic s_ls, s_busy, s_done, s_err;
  logic [1:0] s_idx;
  logic [VW-1:0] s_lin;
  logic [DW-1:0] s_res;
  bit sel;

  layer_sequencer #(.NUM_LAYERS(NL), .NEURONS(N), .LAST_N(LN),
    .DATA_W(DW), .TIMEOUT(TOA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .net_in(net_in),
    .layer_start(a_ls), .layer_idx(a_idx), .layer_in(a_lin),
    .neuron_end(neuron_end), .neuron_out(neuron_out),
    .busy(a_busy), .done(a_done), .result(a_res), .error(a_err));

  layer_sequencer #(.NUM_LAYERS(NL), .NEURONS(N), .LAST_N(LN),
    .DATA_W(DW), .TIMEOUT(TOB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .net_in(net_in),
    .layer_start(b_ls), .layer_idx(b_idx), .layer_in(b_lin),
    .neuron_end(neuron_end), .neuron_out(neuron_out),
    .busy(b_busy), .done(b_done), .result(b_res), .error(b_err));

  always #5 clk = ~clk;

  always_comb begin
    s_ls = sel ? b_ls : a_ls;
    s_busy = sel ? b_busy : a_busy;
    s_done = sel ? b_done : a_done;
    s_err = sel ? b_err : a_err;
    s_idx = sel ? b_idx : a_idx;
    s_lin = sel ? b_lin : a_lin;
    s_res = sel ? b_res : a_res;
  end

  int pass_n = 0;
  int total_n = 0;
  int dly[NL][N];
  logic [DW-1:0] outv[NL][N];
  logic [VW-1:0] nin;
  bit dup_on;
  bit e_ls[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC];
  int e_layer[MAXC];
  int end_c;
  bit m_err_end;
  int obs_done_c;

  typedef struct {
    int d;
    int exp_done;
    logic [DW-1:0] exp_res;
  } row_t;
  row_t tbl[4];

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] want);
    total_n++;
    if (act === want) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic logic [VW-1:0] pack(input int l);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = outv[l][i];
    return v;
  endfunction

  function automatic logic [N-1:0] pulses(input int rel, input int l);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (dly[l][i] == rel) p[i] = 1'b1;
      if (dup_on && l == 0 && i == 3 && rel == 2) p[i] = 1'b1;
    end
    return p;
  endfunction

  // Timeline model: each layer waits for its slowest active neuron.
  task automatic build_model(input bit hold, input bit err0,
                             input int to_val, input int n_evals);
    int t, f, w, na;
    for (int c = 0; c < MAXC; c++) begin
      e_ls[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
      e_layer[c] = -1;
    end
    e_err[0] = err0;
    m_err_end = 0;
    t = 0;
    for (int ev = 0; ev < n_evals; ev++) begin
      f = t + 1;
      for (int l = 0; l < NL; l++) begin
        na = (l == NL - 1) ? LN : N;
        w = 0;
        for (int i = 0; i < na; i++) if (dly[l][i] > w) w = dly[l][i];
        e_ls[f] = 1;
        e_layer[f] = l;
        if (w > to_val) begin
          for (int c = f; c <= f + to_val; c++) e_busy[c] = 1;
          for (int c = f + to_val + 1; c <= f + to_val + 4; c++) e_err[c] = 1;
          end_c = f + to_val + 4;
          m_err_end = 1;
          return;
        end
        for (int c = f; c <= f + w + 1; c++) e_busy[c] = 1;
        f = f + w + 2;
      end
      e_done[f] = 1;
      end_c = hold ? f + 1 : f + 3;
      t = f + 1;
    end
  endtask

  // Called one step after a rising edge; returns at a falling edge.
  task automatic run(input bit hold, input int abort_c);
    int f_last, l_cur;
    f_last = -1000;
    l_cur = 0;
    obs_done_c = -1;
    start = 1'b1;
    net_in = nin;
    neuron_end = '0;
    neuron_out = '0;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      chk($sformatf("ctl c%0d", c), {s_ls, s_busy, s_done, s_err},
          {e_ls[c], e_busy[c], e_done[c], e_err[c]});
      if (s_done && obs_done_c < 0) obs_done_c = c;
      if (e_layer[c] >= 0) begin
        chk($sformatf("idx c%0d", c), VW'(s_idx), VW'(e_layer[c]));
        chk($sformatf("lin c%0d", c), s_lin,
            (e_layer[c] == 0) ? nin : pack(e_layer[c] - 1));
        if (c == 1) chk("res_clr", VW'(s_res), '0);
      end
      if (e_done[c]) chk($sformatf("res c%0d", c), VW'(s_res),
                         VW'(outv[NL-1][0]));
      if (s_ls) begin
        f_last = c;
        l_cur = (s_idx < NL) ? int'(s_idx) : 0;
      end
      if (c == end_c || c == abort_c) break;
      @(posedge clk);
      #1;
      start = hold;
      neuron_out = (f_last >= 0) ? pack(l_cur) : '0;
      neuron_end = (f_last >= 0) ? pulses(c + 1 - f_last, l_cur) : '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    neuron_end = '0;
    neuron_out = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic nominal(input int d);
    dup_on = 0;
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < N; i++) begin
        dly[l][i] = d;
        outv[l][i] = DW'(9'h10 + l);
      end
    for (int i = 0; i < N; i++) nin[i*DW +: DW] = DW'(i);
  endtask

  task automatic randomize_cfg(input int dmax);
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < N; i++) begin
        dly[l][i] = $urandom_range(1, dmax);
        outv[l][i] = DW'($urandom_range(0, 511));
      end
    for (int i = LN; i < N; i++) dly[NL-1][i] = $urandom_range(1, 12);
    for (int i = 0; i < N; i++) nin[i*DW +: DW] = DW'($urandom_range(0, 511));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit perr;
    tbl[0] = '{d: 1, exp_done: 10, exp_res: 9'h012};
    tbl[1] = '{d: 2, exp_done: 13, exp_res: 9'h012};
    tbl[2] = '{d: 4, exp_done: 19, exp_res: 9'h012};
    tbl[3] = '{d: 7, exp_done: 28, exp_res: 9'h012};

    sel = 0;
    dup_on = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_a", {a_ls, a_busy, a_done, a_err, a_idx, a_lin, a_res}, '0);
    chk("rst_b", {b_ls, b_busy, b_done, b_err, b_idx, b_lin, b_res}, '0);
    do_reset();

    foreach (tbl[k]) begin
      do_reset();
      nominal(tbl[k].d);
      build_model(0, 0, TOA, 1);
      run(0, -1);
      chk($sformatf("tbl%0d done_c", k), VW'(obs_done_c), VW'(tbl[k].exp_done));
      chk($sformatf("tbl%0d res", k), VW'(a_res), VW'(tbl[k].exp_res));
    end

    do_reset();
    nominal(1);
    for (int i = 0; i < N; i++) dly[0][i] = i + 1;
    dup_on = 1;
    build_model(0, 0, TOA, 1);
    run(0, -1);
    dup_on = 0;

    do_reset();
    nominal(1);
    for (int i = LN; i < N; i++) dly[NL-1][i] = NEVER;
    build_model(0, 0, TOA, 1);
    run(0, -1);

    do_reset();
    nominal(1);
    build_model(1, 0, TOA, 2);
    run(1, -1);
    chk("hold done_c", VW'(obs_done_c), VW'(10));

    sel = 1;
    do_reset();
    nominal(1);
    dly[1][5] = NEVER;
    build_model(0, 0, TOB, 1);
    run(0, -1);
    chk("to idx", VW'(b_idx), VW'(1));
    chk("to err", VW'(b_err), VW'(1));
    chk("to no_done", VW'(obs_done_c), VW'(-1));
    @(posedge clk);
    #1;
    nominal(1);
    build_model(0, 1, TOB, 1);
    run(0, -1);

    sel = 0;
    do_reset();
    nominal(1);
    build_model(0, 0, TOA, 1);
    run(0, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst", {a_ls, a_busy, a_done, a_err, a_idx, a_lin, a_res}, '0);
    @(posedge clk);
    #1;
    start = 1'b0;
    neuron_end = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst c%0d", c),
          {a_ls, a_busy, a_done, a_err, a_idx}, '0);
    end
    @(posedge clk);
    #1;

    do_reset();
    for (int r = 0; r < 20; r++) begin
      randomize_cfg(5);
      build_model(0, 0, TOA, 1);
      run(0, -1);
      @(posedge clk);
      #1;
    end

    sel = 1;
    do_reset();
    perr = 0;
    for (int r = 0; r < 20; r++) begin
      randomize_cfg(6);
      build_model(0, perr, TOB, 1);
      perr = m_err_end;
      run(0, -1);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
